// File: rtl/bb_and_sequencer_pkg.sv
// rtl/bb_and_sequencer_pkg.sv - shared state type and width helpers for bb_and_sequencer
package bb_and_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the bit counter walking through one operand.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bb_and_sequencer_rr_arbiter.sv
// rtl/bb_and_sequencer_rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    // Walk upward from ptr, wrapping, and grant the first active request.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bb_and_sequencer.sv
// rtl/bb_and_sequencer.sv - serialises multi-bit ANDs through a shared 1-bit black box
module bb_and_sequencer
    import bb_and_sequencer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int ID_W   = id_w(NUM_REQ),
    localparam int CNT_W  = cnt_w(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDTH-1:0]           resp_result,
    output logic                       bb_a,
    output logic                       bb_b,
    input  logic                       bb_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    seq_state_t           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      id_reg;
    logic [ID_W-1:0]      grant_idx;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     res_reg;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Binary index of the one-hot grant, used to pick the operand slice.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = ID_W'(i);
        end
    end

    // Accept strobes only in IDLE; gated by reset so nothing is offered while held in reset.
    assign req_ready   = (state == IDLE && reset) ? grant : '0;
    assign bb_a        = (state == RUN) ? a_reg[cnt] : 1'b0;
    assign bb_b        = (state == RUN) ? b_reg[cnt] : 1'b0;
    assign resp_valid  = (state == DONE);
    assign resp_id     = id_reg;
    assign resp_result = res_reg;

    // Sequencer: accept one request, feed the black box bit by bit, hold the result until taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        a_reg   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        b_reg   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        id_reg  <= grant_idx;
                        cnt     <= '0;
                        res_reg <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_reg[cnt] <= bb_result;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        rr_ptr <= (id_reg == ID_LAST) ? '0 : id_reg + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bb_and_sequencer.sv
// tb/tb_bb_and_sequencer.sv - randomized self-checking bench for bb_and_sequencer
module tb_bb_and_sequencer;

    localparam int N = 4;
    localparam int W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_result;
    logic             bb_a, bb_b, bb_result;

    logic             reset1 = 1'b0;
    logic [0:0]       req_valid1 = '0;
    logic [0:0]       req_ready1;
    logic [0:0]       req_a1 = '0;
    logic [0:0]       req_b1 = '0;
    logic             resp_valid1;
    logic             resp_ready1 = 1'b0;
    logic [0:0]       resp_id1;
    logic [0:0]       resp_result1;
    logic             bb_a1, bb_b1, bb_result1;

    always #5 clock = ~clock;

    assign bb_result  = bb_a & bb_b;
    assign bb_result1 = bb_a1 & bb_b1;

    bb_and_sequencer #(.NUM_REQ(N), .WIDTH(W)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .bb_a(bb_a), .bb_b(bb_b), .bb_result(bb_result)
    );

    bb_and_sequencer #(.NUM_REQ(1), .WIDTH(1)) u_dut1 (
        .clock(clock), .reset(reset1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_id(resp_id1), .resp_result(resp_result1),
        .bb_a(bb_a1), .bb_b(bb_b1), .bb_result(bb_result1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side pending operations
    bit           pv [N];
    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];

    // Transaction-level reference: one operation in flight, its age in cycles since acceptance
    bit           m_busy = 0;
    int           m_t    = 0;
    int           m_id   = 0;
    int           m_ptr  = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_id = 0; m_ptr = 0; m_a = '0; m_b = '0;
    endtask

    // One clock cycle: drive inputs, compare against the reference, advance the reference.
    // rr_mode: 0 random resp_ready, 1 always ready, 2 never ready
    task automatic step(input int p_new, input int rr_mode);
        int           w;
        logic [N-1:0] exp_ready;
        bit           exp_rv;
        logic         exp_bit_a, exp_bit_b;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (!pv[i] && int'($urandom_range(99)) < p_new) begin
                pv[i] = 1; pa[i] = W'($urandom); pb[i] = W'($urandom);
            end
            req_valid[i]       = pv[i];
            req_a[i*W +: W]    = pa[i];
            req_b[i*W +: W]    = pb[i];
        end
        resp_ready = (rr_mode == 0) ? 1'($urandom_range(1)) : (rr_mode == 1);
        #1;
        w = -1;
        exp_ready = '0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        exp_rv    = m_busy && (m_t > W);
        exp_bit_a = (m_busy && m_t >= 1 && m_t <= W) ? m_a[m_t-1] : 1'b0;
        exp_bit_b = (m_busy && m_t >= 1 && m_t <= W) ? m_b[m_t-1] : 1'b0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check("resp_id", 64'(resp_id), 64'(m_id));
        if (exp_rv) check("resp_result", 64'(resp_result), 64'(m_a & m_b));
        check("bb_a", 64'(bb_a), 64'(exp_bit_a));
        check("bb_b", 64'(bb_b), 64'(exp_bit_b));
        if (w >= 0) begin
            m_busy = 1; m_id = w; m_a = pa[w]; m_b = pb[w]; m_t = 1; pv[w] = 0;
        end else if (m_busy) begin
            if (exp_rv && resp_ready) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % N;
            end else if (m_t <= W) begin
                m_t++;
            end
        end
    endtask

    task automatic drain();
        bit any;
        for (int k = 0; k < 200; k++) begin
            any = m_busy;
            for (int i = 0; i < N; i++) any |= pv[i];
            if (!any) break;
            step(0, 1);
        end
        if (m_busy) check("drain_timeout", 64'(m_busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; end
        model_reset();

        // Reset state of both instances
        repeat (2) @(negedge clock);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_id", 64'(resp_id), 64'(0));
        check("rst_resp_result", 64'(resp_result), 64'(0));
        check("rst_bb_a", 64'(bb_a), 64'(0));
        check("rst_bb_b", 64'(bb_b), 64'(0));
        check("rst1_resp_valid", 64'(resp_valid1), 64'(0));
        reset  = 1'b1;
        reset1 = 1'b1;

        // Single request from requester 2: 0xF0 & 0xCC
        pv[2] = 1; pa[2] = 8'hF0; pb[2] = 8'hCC;
        repeat (12) step(0, 1);

        // Requester 1 only: all-ones, then zero against all-ones
        pv[1] = 1; pa[1] = 8'hFF; pb[1] = 8'hFF;
        repeat (12) step(0, 1);
        pv[1] = 1; pa[1] = 8'h00; pb[1] = 8'hFF;
        repeat (12) step(0, 1);

        // All requesters continuously valid, consumer always ready
        repeat (60) step(100, 1);

        // Backpressure held, then released
        repeat (25) step(100, 2);
        repeat (20) step(100, 1);

        // Random traffic and random backpressure
        repeat (400) step(40, 0);
        drain();

        // Reset in the middle of RUN, then the pending request is re-accepted
        pv[2] = 1; pa[2] = 8'hF0; pb[2] = 8'hCC;
        for (int k = 0; k < 20 && !(m_busy && m_t == 4); k++) step(0, 1);
        if (!(m_busy && m_t == 4)) check("mid_run_reach", 64'(m_t), 64'(4));
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mr_req_ready", 64'(req_ready), 64'(0));
        check("mr_resp_valid", 64'(resp_valid), 64'(0));
        check("mr_resp_id", 64'(resp_id), 64'(0));
        check("mr_resp_result", 64'(resp_result), 64'(0));
        check("mr_bb_a", 64'(bb_a), 64'(0));
        check("mr_bb_b", 64'(bb_b), 64'(0));
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        pv[2] = 1;
        repeat (14) step(0, 1);
        drain();

        // NUM_REQ=1, WIDTH=1 instance: 1 & 1
        @(negedge clock);
        req_valid1 = 1'b1; req_a1 = 1'b1; req_b1 = 1'b1; resp_ready1 = 1'b1;
        #1;
        check("w1_req_ready", 64'(req_ready1), 64'(1));
        check("w1_c0_resp_valid", 64'(resp_valid1), 64'(0));
        @(negedge clock);
        req_valid1 = 1'b0;
        #1;
        check("w1_bb_a", 64'(bb_a1), 64'(1));
        check("w1_bb_b", 64'(bb_b1), 64'(1));
        check("w1_c1_resp_valid", 64'(resp_valid1), 64'(0));
        @(negedge clock);
        #1;
        check("w1_c2_resp_valid", 64'(resp_valid1), 64'(1));
        check("w1_resp_result", 64'(resp_result1), 64'(1));
        check("w1_resp_id", 64'(resp_id1), 64'(0));
        check("w1_c2_bb_a", 64'(bb_a1), 64'(0));
        @(negedge clock);
        #1;
        check("w1_c3_resp_valid", 64'(resp_valid1), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
